// File: rtl/sw_mode_select.sv
// Synchronizes and debounces four slide switches, priority-encodes them into a registered mode.
// Latency: DEBOUNCE_CYCLES+3 edges from a stable raw level to mode/mode_change.
// No backpressure: free-running stage, outputs update every cycle.
module sw_mode_select #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  output logic [3:0] sw_clean,
  output logic [2:0] mode,
  output logic       mode_change
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [2:0] MODE_OFF        = 3'd0;
  localparam logic [2:0] MODE_LINEAR     = 3'd1;
  localparam logic [2:0] MODE_SINE       = 3'd2;
  localparam logic [2:0] MODE_RAINBOW    = 3'd3;
  localparam logic [2:0] MODE_SOLID_BLUE = 3'd4;

  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [CNT_W-1:0] cnt [4];
  logic [2:0]       mode_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

  // Any return to the accepted level clears the count, so glitches never accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_clean <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == sw_clean[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          sw_clean[i] <= s2[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    mode_nxt = MODE_OFF;
    if (sw_clean[0]) begin
      mode_nxt = MODE_LINEAR;
    end else if (sw_clean[1]) begin
      mode_nxt = MODE_SINE;
    end else if (sw_clean[2]) begin
      mode_nxt = MODE_RAINBOW;
    end else if (sw_clean[3]) begin
      mode_nxt = MODE_SOLID_BLUE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode        <= MODE_OFF;
      mode_change <= 1'b0;
    end else begin
      mode        <= mode_nxt;
      mode_change <= (mode_nxt != mode);
    end
  end

endmodule

// File: tb/tb_sw_mode_select.sv
// Directed per-cycle vector table plus a mid-operation reset sequence, DEBOUNCE_CYCLES=4.
module tb_sw_mode_select;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw  = 4'hF;
  logic [3:0] sw_clean;
  logic [2:0] mode;
  logic       mode_change;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic [3:0] sw;
    logic [3:0] clean;
    logic [2:0] mode;
    logic       chg;
  } vec_t;

  vec_t vecs[$];

  sw_mode_select #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .sw_clean    (sw_clean),
    .mode        (mode),
    .mode_change (mode_change)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] c, input logic [2:0] m, input logic g);
    check({tag, ".sw_clean"}, 32'(sw_clean), 32'(c));
    check({tag, ".mode"}, 32'(mode), 32'(m));
    check({tag, ".mode_change"}, 32'(mode_change), 32'(g));
  endtask

  task automatic add(input logic r, input logic [3:0] s, input logic [3:0] c,
                     input logic [2:0] m, input logic g, input int n);
    vec_t v;
    v.rst = r; v.sw = s; v.clean = c; v.mode = m; v.chg = g;
    repeat (n) vecs.push_back(v);
  endtask

  initial begin
    // Each record: inputs applied before an edge, outputs expected just after it.
    // Reset held with all switches up, then full requalification after release.
    add(1, 4'hF, 4'h0, 3'd0, 0, 3);
    add(0, 4'hF, 4'h0, 3'd0, 0, 5);
    add(0, 4'hF, 4'hF, 3'd0, 0, 1);
    add(0, 4'hF, 4'hF, 3'd1, 1, 1);
    add(0, 4'hF, 4'hF, 3'd1, 0, 1);
    // Release all switches.
    add(0, 4'h0, 4'hF, 3'd1, 0, 5);
    add(0, 4'h0, 4'h0, 3'd1, 0, 1);
    add(0, 4'h0, 4'h0, 3'd0, 1, 1);
    add(0, 4'h0, 4'h0, 3'd0, 0, 1);
    // Clean press of sw[0].
    add(0, 4'h1, 4'h0, 3'd0, 0, 5);
    add(0, 4'h1, 4'h1, 3'd0, 0, 1);
    add(0, 4'h1, 4'h1, 3'd1, 1, 1);
    add(0, 4'h1, 4'h1, 3'd1, 0, 1);
    // Priority: sw[2] added under sw[0] gives no pulse; dropping sw[0] gives RAINBOW.
    add(0, 4'h5, 4'h1, 3'd1, 0, 5);
    add(0, 4'h5, 4'h5, 3'd1, 0, 2);
    add(0, 4'h4, 4'h5, 3'd1, 0, 5);
    add(0, 4'h4, 4'h4, 3'd1, 0, 1);
    add(0, 4'h4, 4'h4, 3'd3, 1, 1);
    add(0, 4'h4, 4'h4, 3'd3, 0, 1);
    add(0, 4'h0, 4'h4, 3'd3, 0, 5);
    add(0, 4'h0, 4'h0, 3'd3, 0, 1);
    add(0, 4'h0, 4'h0, 3'd0, 1, 1);
    add(0, 4'h0, 4'h0, 3'd0, 0, 1);
    // Three-cycle glitch on sw[1] is rejected.
    add(0, 4'h2, 4'h0, 3'd0, 0, 3);
    add(0, 4'h0, 4'h0, 3'd0, 0, 8);
    // Four-cycle hold is accepted; release pulses exactly DEBOUNCE_CYCLES later.
    add(0, 4'h2, 4'h0, 3'd0, 0, 4);
    add(0, 4'h0, 4'h0, 3'd0, 0, 1);
    add(0, 4'h0, 4'h2, 3'd0, 0, 1);
    add(0, 4'h0, 4'h2, 3'd2, 1, 1);
    add(0, 4'h0, 4'h2, 3'd2, 0, 2);
    add(0, 4'h0, 4'h0, 3'd2, 0, 1);
    add(0, 4'h0, 4'h0, 3'd0, 1, 1);
    add(0, 4'h0, 4'h0, 3'd0, 0, 1);
    // Simultaneous sw[2]/sw[3]: one update, one pulse; then SOLID_BLUE.
    add(0, 4'hC, 4'h0, 3'd0, 0, 5);
    add(0, 4'hC, 4'hC, 3'd0, 0, 1);
    add(0, 4'hC, 4'hC, 3'd3, 1, 1);
    add(0, 4'hC, 4'hC, 3'd3, 0, 1);
    add(0, 4'h8, 4'hC, 3'd3, 0, 5);
    add(0, 4'h8, 4'h8, 3'd3, 0, 1);
    add(0, 4'h8, 4'h8, 3'd4, 1, 1);
    add(0, 4'h8, 4'h8, 3'd4, 0, 1);
    // sw[1] then sw[0] one cycle apart: two back-to-back pulses.
    add(0, 4'hA, 4'h8, 3'd4, 0, 1);
    add(0, 4'hB, 4'h8, 3'd4, 0, 4);
    add(0, 4'hB, 4'hA, 3'd4, 0, 1);
    add(0, 4'hB, 4'hB, 3'd2, 1, 1);
    add(0, 4'hB, 4'hB, 3'd1, 1, 1);
    add(0, 4'hB, 4'hB, 3'd1, 0, 1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      sw  = vecs[i].sw;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].clean, vecs[i].mode, vecs[i].chg);
    end

    // Mid-operation reset while sw[0] has counted to 2.
    rst = 1'b1;
    sw  = 4'h0;
    repeat (2) step();
    check_all("midrst.pre", 4'h0, 3'd0, 1'b0);
    rst = 1'b0;
    step();
    sw = 4'h1;
    repeat (4) step();
    check("midrst.counting", 32'(sw_clean), 32'h0);
    rst = 1'b1;
    step();
    check_all("midrst.during", 4'h0, 3'd0, 1'b0);
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      check_all($sformatf("midrst.edge%0d", e),
                (e >= 6) ? 4'h1 : 4'h0,
                (e >= 7) ? 3'd1 : 3'd0,
                (e == 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/sw_mode_select.md
# sw_mode_select

Input-conditioning stage that sits directly upstream of the top-level LED mode multiplexer. It synchronizes and debounces the four raw slide switches, resolves them by fixed priority into a registered mode code, and flags every mode change with a one-cycle pulse. Downstream logic consumes a glitch-free, registered mode instead of raw asynchronous switch levels.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive cycles a synchronized switch level must differ from its accepted level before it is accepted. This is 10 ms at 100 MHz. Legal range is 2 to 2^24.
- CNT_W, $clog2(DEBOUNCE_CYCLES): width of each per-bit debounce counter. This is derived; it is not overridden.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- sw  in  4  raw slide switches, asynchronous to clk.
- sw_clean  out  4  debounced switch levels, registered.
- mode  out  3  registered mode code: 0 OFF, 1 LINEAR, 2 SINE, 3 RAINBOW, 4 SOLID_BLUE. Codes 5–7 are never driven.
- mode_change  out  1  one-cycle pulse, asserted in the cycle `mode` takes a new value.

## Operation
- **Synchronizer:** each sw bit passes through a 2-flop synchronizer (s1, then s2). Both flops reset to 0.
- **Debounce:** each bit has an independent counter cnt[i] (CNT_W bits) and an accepted level sw_clean[i]. Per clock edge:
  - If s2[i] equals sw_clean[i]: cnt[i] is set to 0.
  - Else if cnt[i] equals DEBOUNCE_CYCLES-1: sw_clean[i] is set to s2[i] and cnt[i] is set to 0.
  - Else: cnt[i] is incremented by 1.
  - cnt[i] never exceeds DEBOUNCE_CYCLES-1, so no wrap-around is possible.
- **Glitch rejection:** a level excursion shorter than DEBOUNCE_CYCLES synchronized cycles never reaches sw_clean. Any return to the accepted level clears the counter, so partial counts do not accumulate across glitches.
- **Priority encode:** combinational from sw_clean. The lowest-index set bit wins:
  - sw_clean[0] → LINEAR
  - otherwise sw_clean[1] → SINE
  - otherwise sw_clean[2] → RAINBOW
  - otherwise sw_clean[3] → SOLID_BLUE
  - no bits set → OFF
- **Mode register:** every edge, mode is loaded with the encoder output. mode_change is registered as (encoder output ≠ current mode).
  - A sw_clean change that does not alter the encoded mode produces no pulse. Example: sw_clean[3] toggling while sw_clean[0]=1.
- **Simultaneous events:** bits debounce independently. If two bits are accepted on the same edge, the encoder sees both, and exactly one mode update and one pulse result.
- **Reset, including mid-operation:**
  - s1, s2, cnt, sw_clean are all cleared to 0. mode is set to 0 (OFF). mode_change is set to 0.
  - In-progress counts are discarded.
  - A switch held high across reset must be re-qualified for the full DEBOUNCE_CYCLES after release.

## Timing
- **Reset values:** sw_clean=4'b0000, mode=3'd0, mode_change=0. These hold every cycle while rst=1.
- **Sampling:** a raw level on sw that is stable before edge k is captured in s1 at edge k and in s2 at edge k+1.
- **Debounce latency:** with that level held and different from the accepted level, sw_clean updates at edge k+1+DEBOUNCE_CYCLES.
- **Mode latency:** mode and mode_change update at edge k+2+DEBOUNCE_CYCLES.
  - Total switch-to-mode latency is DEBOUNCE_CYCLES+3 edges, counting from edge k.
  - mode_change is high for exactly the one cycle after that edge.
- **Back-to-back changes:** two mode changes on consecutive edges produce two consecutive single-cycle pulses, one per change.
- **Pulse spacing:** pulses arise only from accepted sw_clean changes. For a single switch, consecutive pulses are therefore separated by at least DEBOUNCE_CYCLES cycles.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Reset:** hold rst for 3 cycles with sw=4'b1111. Check sw_clean=0, mode=0, mode_change=0 throughout. After release, check mode=1 exactly 7 edges later, with a single pulse.
- **Clean press:** sw goes 0000→0001 before edge k. Check sw_clean[0]=1 at edge k+5. Check mode=1 and mode_change=1 at edge k+6. Check mode_change=0 at edge k+7.
- **Glitch rejection:** pulse sw[1] high for 3 cycles, then low. Check sw_clean, mode and mode_change never change. Then hold sw[1] high for 4 cycles and check the change is accepted: sw_clean[1]=1, mode=2.
- **Priority:** with sw=0001 settled (mode=1), set sw=0101. Check sw_clean=0101 and that mode stays 1 with no pulse. Then clear sw[0]. Check mode=3 and exactly one pulse.
- **Simultaneous:** from sw=0000, set sw=1100 on the same edge. Check both bits accepted on the same edge, mode=3, and exactly one pulse. Then clear sw[2] and check mode=4.
- **Mid-operation reset:** assert rst for 1 cycle while cnt[0]=2 counting toward a press. After release, with sw[0] still held, check sw_clean[0]=1 only at the 6th edge after release and mode=1 one edge later.
